// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial config loader for the fabric chain; optional CRC-8 check under PROG_LOADER_CRC_EN
module prog_loader #(
  parameter int CHAIN_LEN = 24,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              prog_in,
  output logic              prog_en,
  input  logic              prog_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              crc_err
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BCW    = $clog2(CHAIN_LEN + 1);
  localparam int WCW    = $clog2(NWORDS + 1);
  localparam int LCW    = $clog2(WORD_W);

  localparam logic [BCW-1:0] LAST_BIT  = BCW'(CHAIN_LEN);
  localparam logic [WCW-1:0] MAX_WORDS = WCW'(NWORDS);
  localparam logic [LCW-1:0] FULL_LEFT = LCW'(WORD_W - 1);

`ifdef PROG_LOADER_CRC_EN
  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_SHIFT, S_CHECK, S_FINISH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_SHIFT, S_FINISH} state_t;
`endif

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;       // bits of the current word still to drive, MSB aligned
  logic [LCW-1:0]    left_q, left_d;       // bits remaining in sreg
  logic [WORD_W-1:0] hold_q, hold_d;       // one-word prefetch buffer
  logic              hold_vld_q, hold_vld_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic              prog_en_q, prog_en_d;
  logic              prog_in_q, prog_in_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              cfg_ready_c;
  logic              done_c;
  logic              crc_shift_c;          // a chain bit is driven on this edge
  logic              crc_clr_c;
  logic              crc_chk_c;            // trailing CRC word accepted this edge
  logic              accept;
  logic [WORD_W-1:0] next_word;

  assign accept    = cfg_valid && cfg_ready_c;
  assign next_word = hold_vld_q ? hold_q : cfg_data;

  // Next-state, datapath and handshake decode for the load sequence
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    left_d      = left_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    prog_en_d   = prog_en_q;
    prog_in_d   = prog_in_q;
    busy_d      = busy_q;
    err_d       = err_q;
    cfg_ready_c = 1'b0;
    done_c      = 1'b0;
    crc_shift_c = 1'b0;
    crc_clr_c   = 1'b0;
    crc_chk_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_PRIME;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          hold_vld_d = 1'b0;
          crc_clr_c  = 1'b1;
        end
      end

      S_PRIME: begin
        cfg_ready_c = 1'b1;
        if (cfg_valid) begin
          sreg_d      = {cfg_data[WORD_W-2:0], 1'b0};
          left_d      = FULL_LEFT;
          prog_en_d   = 1'b1;
          prog_in_d   = cfg_data[WORD_W-1];
          bit_cnt_d   = BCW'(1);
          word_cnt_d  = word_cnt_q + 1'b1;
          crc_shift_c = 1'b1;
          state_d     = S_SHIFT;
        end
      end

      S_SHIFT: begin
        cfg_ready_c = !hold_vld_q && (word_cnt_q < MAX_WORDS);
        if (accept) begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
        if (bit_cnt_q == LAST_BIT) begin
          // Last bit has just been sampled by the chain; the falling enable latches it.
          prog_en_d = 1'b0;
          prog_in_d = 1'b0;
`ifdef PROG_LOADER_CRC_EN
          state_d   = S_CHECK;
`else
          state_d   = S_FINISH;
`endif
        end else if (left_q != '0) begin
          prog_in_d   = sreg_q[WORD_W-1];
          sreg_d      = {sreg_q[WORD_W-2:0], 1'b0};
          left_d      = left_q - 1'b1;
          bit_cnt_d   = bit_cnt_q + 1'b1;
          crc_shift_c = 1'b1;
          if (accept) begin
            hold_d     = cfg_data;
            hold_vld_d = 1'b1;
          end
        end else if (hold_vld_q || accept) begin
          // Word boundary: take the prefetched word, or the one arriving right now.
          prog_in_d   = next_word[WORD_W-1];
          sreg_d      = {next_word[WORD_W-2:0], 1'b0};
          left_d      = FULL_LEFT;
          hold_vld_d  = 1'b0;
          bit_cnt_d   = bit_cnt_q + 1'b1;
          crc_shift_c = 1'b1;
        end else begin
          // Underrun: stop shifting so the chain latches what it has.
          prog_en_d = 1'b0;
          prog_in_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_FINISH;
        end
      end

`ifdef PROG_LOADER_CRC_EN
      S_CHECK: begin
        cfg_ready_c = 1'b1;
        if (cfg_valid) begin
          crc_chk_c = 1'b1;
          state_d   = S_FINISH;
        end
      end
`endif

      S_FINISH: begin
        done_c  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      left_q     <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      prog_en_q  <= 1'b0;
      prog_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      left_q     <= left_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      prog_en_q  <= prog_en_d;
      prog_in_q  <= prog_in_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

`ifdef PROG_LOADER_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic       crc_err_q, crc_err_d;
  logic       unused_prog_out;

  assign unused_prog_out = prog_out;

  // CRC-8 (poly 0x07) over each driven chain bit, compared against the trailing word
  always_comb begin
    crc_d     = crc_q;
    crc_err_d = crc_err_q;
    if (crc_clr_c) begin
      crc_d     = 8'h00;
      crc_err_d = 1'b0;
    end else if (crc_shift_c) begin
      crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ prog_in_d) ? 8'h07 : 8'h00);
    end
    if (crc_chk_c) begin
      crc_err_d = (cfg_data[7:0] != crc_q);
    end
  end

  // CRC accumulator and sticky mismatch flag
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      crc_q     <= 8'h00;
      crc_err_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign crc_err = crc_err_q;
`else
  logic unused_crc_sigs;

  assign unused_crc_sigs = prog_out ^ crc_shift_c ^ crc_clr_c ^ crc_chk_c;
  assign crc_err         = 1'b0;
`endif

  assign cfg_ready = cfg_ready_c;
  assign done      = done_c;
  assign prog_in   = prog_in_q;
  assign prog_en   = prog_en_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - bench for prog_loader at CHAIN_LEN 24 and 20 (CRC checks under PROG_LOADER_CRC_EN)
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       prog_rst_n = 1'b0;
  logic       start_s     [2];
  logic [7:0] cfg_data_s  [2];
  logic       cfg_valid_s [2];
  logic       cfg_ready_s [2];
  logic       prog_in_s   [2];
  logic       prog_en_s   [2];
  logic       prog_out_s  [2];
  logic       busy_s      [2];
  logic       done_s      [2];
  logic       err_s       [2];
  logic       crc_err_s   [2];

  logic [23:0] chain0 = '0;
  logic [19:0] chain1 = '0;

  int n_assert = 0;
  int n_fail   = 0;

  // monitor state (written only by the monitor process)
  logic [63:0] cap      [2] = '{64'd0, 64'd0};
  int          en_cnt   [2] = '{0, 0};
  int          en_rise  [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          acc_cnt  [2] = '{0, 0};
  logic        en_prev  [2] = '{1'b0, 1'b0};

  // reference model results
  logic [7:0]  words_q[$];
  int          exp_nb, exp_acc;
  logic [63:0] exp_val;
  logic        exp_under, exp_crc_err;

  always #5 clk = ~clk;

  prog_loader #(.CHAIN_LEN(24), .WORD_W(8)) dut24 (
    .prog_clk(clk), .prog_rst_n(prog_rst_n), .start(start_s[0]),
    .cfg_data(cfg_data_s[0]), .cfg_valid(cfg_valid_s[0]), .cfg_ready(cfg_ready_s[0]),
    .prog_in(prog_in_s[0]), .prog_en(prog_en_s[0]), .prog_out(prog_out_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0]), .crc_err(crc_err_s[0])
  );

  prog_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut20 (
    .prog_clk(clk), .prog_rst_n(prog_rst_n), .start(start_s[1]),
    .cfg_data(cfg_data_s[1]), .cfg_valid(cfg_valid_s[1]), .cfg_ready(cfg_ready_s[1]),
    .prog_in(prog_in_s[1]), .prog_en(prog_en_s[1]), .prog_out(prog_out_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1]), .crc_err(crc_err_s[1])
  );

  // downstream chains: tails feed prog_out
  always @(posedge clk) begin
    if (prog_en_s[0]) chain0 <= {chain0[22:0], prog_in_s[0]};
    if (prog_en_s[1]) chain1 <= {chain1[18:0], prog_in_s[1]};
  end
  assign prog_out_s[0] = chain0[23];
  assign prog_out_s[1] = chain1[19];

  // sample outputs mid-cycle: serial stream, enable runs, done pulses, handshakes
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (prog_en_s[s]) begin
        cap[s]    = {cap[s][62:0], prog_in_s[s]};
        en_cnt[s] = en_cnt[s] + 1;
        if (!en_prev[s]) en_rise[s] = en_rise[s] + 1;
      end
      en_prev[s] = prog_en_s[s];
      if (done_s[s]) done_cnt[s] = done_cnt[s] + 1;
      if (cfg_valid_s[s] && cfg_ready_s[s]) acc_cnt[s] = acc_cnt[s] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8_bits(input logic [63:0] v, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[7] ^ v[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // What a load of words_q into a chain of L bits should produce
  task automatic model(input int L);
    int need, nd;
    need      = (L + 7) / 8;
    nd        = (words_q.size() < need) ? words_q.size() : need;
    exp_under = (8 * nd < L);
    exp_nb    = exp_under ? 8 * nd : L;
    exp_val   = '0;
    for (int i = 0; i < exp_nb; i++) exp_val = {exp_val[62:0], words_q[i / 8][7 - (i % 8)]};
    exp_acc     = nd;
    exp_crc_err = 1'b0;
`ifdef PROG_LOADER_CRC_EN
    if (!exp_under && words_q.size() > need) begin
      exp_acc     = nd + 1;
      exp_crc_err = (words_q[need] != crc8_bits(exp_val, exp_nb));
    end
`endif
  endtask

  // Drive one load of words_q into instance s, then compare against the model
  task automatic run_load(input int s, input int L, input int gap_max, input int poke, input string tag);
    int          idx, gap, cyc, b_en, b_rise, b_done, b_acc;
    bit          acc;
    logic [63:0] mask;
    model(L);
    b_en = en_cnt[s]; b_rise = en_rise[s]; b_done = done_cnt[s]; b_acc = acc_cnt[s];
    @(posedge clk); #1 start_s[s] = 1'b1;
    @(posedge clk); #1 start_s[s] = 1'b0;
    idx = 0; cyc = 0; gap = $urandom_range(0, gap_max);
    while (done_cnt[s] == b_done && cyc < 400) begin
      if (idx < words_q.size() && gap == 0) begin
        cfg_valid_s[s] = 1'b1;
        cfg_data_s[s]  = words_q[idx];
      end else begin
        cfg_valid_s[s] = 1'b0;
        cfg_data_s[s]  = 8'($urandom);
        if (gap > 0) gap--;
      end
      start_s[s] = (cyc == poke);
      @(negedge clk);
      acc = cfg_valid_s[s] && cfg_ready_s[s];
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        gap = $urandom_range(0, gap_max);
      end
      cyc++;
    end
    start_s[s] = 1'b0;
    repeat (2) @(posedge clk);
    #1 cfg_valid_s[s] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mask = (64'd1 << exp_nb) - 64'd1;
    chk({tag, "_en_cycles"}, 64'(en_cnt[s] - b_en), 64'(exp_nb));
    chk({tag, "_en_runs"},   64'(en_rise[s] - b_rise), 64'd1);
    chk({tag, "_bits"},      cap[s] & mask, exp_val);
    chk({tag, "_done"},      64'(done_cnt[s] - b_done), 64'd1);
    chk({tag, "_accepted"},  64'(acc_cnt[s] - b_acc), 64'(exp_acc));
    chk({tag, "_err"},       64'(err_s[s]), 64'(exp_under));
    chk({tag, "_crc_err"},   64'(crc_err_s[s]), 64'(exp_crc_err));
    chk({tag, "_busy"},      64'(busy_s[s]), 64'd0);
    chk({tag, "_prog_en"},   64'(prog_en_s[s]), 64'd0);
  endtask

  initial begin
    int          cyc, s, L, need, nd, b_done;
    logic [7:0]  c;

    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; cfg_valid_s[i] = 1'b0; cfg_data_s[i] = 8'h00;
    end

    // reset state, with start asserted during reset
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst_prog_en",   64'(prog_en_s[0]), 64'd0);
    chk("rst_prog_in",   64'(prog_in_s[0]), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready_s[0]), 64'd0);
    chk("rst_busy",      64'(busy_s[0]), 64'd0);
    chk("rst_done",      64'(done_s[0]), 64'd0);
    chk("rst_err",       64'(err_s[0]), 64'd0);
    chk("rst_crc_err",   64'(crc_err_s[0]), 64'd0);
    chk("rst_busy20",    64'(busy_s[1]), 64'd0);
    start_s[0] = 1'b0;
    @(posedge clk); #1 prog_rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("start_in_reset_busy",  64'(busy_s[0]), 64'd0);
    chk("start_in_reset_ready", 64'(cfg_ready_s[0]), 64'd0);

    // 24-bit chain, three back-to-back words
    words_q = '{8'hA5, 8'h3C, 8'h0F};
`ifdef PROG_LOADER_CRC_EN
    words_q.push_back(crc8_bits(64'hA53C0F, 24));
`endif
    run_load(0, 24, 0, -1, "l24");
    chk("l24_control", cap[0] & 64'hFFFFFF, 64'hA53C0F);

    // 20-bit chain: low nibble of the third word dropped, fourth word not consumed as data
    words_q = '{8'hFF, 8'h00, 8'hF7, 8'hAA};
    run_load(1, 20, 0, -1, "l20");
    chk("l20_control", cap[1] & 64'hFFFFF, 64'hFF00F);

    // underrun after a single word
    words_q = '{8'hA5};
    run_load(0, 24, 0, -1, "under");

    // start pulsed mid-shift is ignored; err cleared by the new start
    words_q = '{8'h12, 8'h34, 8'h56, 8'h78};
`ifdef PROG_LOADER_CRC_EN
    model(24);
    words_q[3] = crc8_bits(exp_val, exp_nb);
`endif
    run_load(0, 24, 0, 10, "midstart");

    // reset asserted after 10 bits
    b_done = done_cnt[0];
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    cfg_valid_s[0] = 1'b1; cfg_data_s[0] = 8'hA5;
    cyc = en_cnt[0] + 10;
    for (int k = 0; k < 100 && en_cnt[0] < cyc; k++) begin
      @(posedge clk); #1;
    end
    chk("rstmid_reached", 64'(en_cnt[0]), 64'(cyc));
    prog_rst_n = 1'b0;
    #1;
    chk("rstmid_prog_en",   64'(prog_en_s[0]), 64'd0);
    chk("rstmid_busy",      64'(busy_s[0]), 64'd0);
    chk("rstmid_cfg_ready", 64'(cfg_ready_s[0]), 64'd0);
    cfg_valid_s[0] = 1'b0;
    @(posedge clk); #1 prog_rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rstmid_no_done", 64'(done_cnt[0] - b_done), 64'd0);

    // clean reload after reset
    words_q = '{8'hA5, 8'h3C, 8'h0F};
`ifdef PROG_LOADER_CRC_EN
    words_q.push_back(crc8_bits(64'hA53C0F, 24) ^ 8'h01);
`endif
    run_load(0, 24, 0, -1, "reload");
    chk("reload_control", cap[0] & 64'hFFFFFF, 64'hA53C0F);

    // randomized loads on both chains
    for (int r = 0; r < 10; r++) begin
      s    = r % 2;
      L    = (s == 0) ? 24 : 20;
      need = (L + 7) / 8;
      nd   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, need - 1) : need + $urandom_range(0, 1);
      words_q = {};
      for (int k = 0; k < nd; k++) words_q.push_back(8'($urandom));
`ifdef PROG_LOADER_CRC_EN
      if (nd >= need) begin
        model(L);
        c = crc8_bits(exp_val, exp_nb);
        if ($urandom_range(0, 1) == 1) c = c ^ (8'h01 << $urandom_range(0, 7));
        if (words_q.size() > need) words_q[need] = c;
        else words_q.push_back(c);
      end
`else
      c = 8'h00;
`endif
      run_load(s, L, 3, ($urandom_range(0, 1) == 1) ? 10 : -1, $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
